// File: rtl/swap_arbiter_pkg.sv
// Shared types and helpers for the swap_arbiter block.
package swap_arbiter_pkg;

  typedef enum logic [1:0] {
    PM_PASS = 2'd0,
    PM_SWAP = 2'd1,
    PM_REV  = 2'd2,
    PM_ROTL = 2'd3
  } perm_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swap_arbiter_permute.sv
// Registered bit-permutation stage: loads perm(in_data, mode) when load=1.
module bit_permute_stage
  import swap_arbiter_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] q
);

  logic [W-1:0] perm;

  always_comb begin
    perm = in_data;
    case (mode)
      PM_PASS: perm = in_data;
      PM_SWAP: begin
        for (int unsigned k = 0; k < W / 2; k++) begin
          perm[2*k]   = in_data[2*k+1];
          perm[2*k+1] = in_data[2*k];
        end
      end
      PM_REV: begin
        for (int unsigned j = 0; j < W; j++) begin
          perm[j] = in_data[W-1-j];
        end
      end
      PM_ROTL: perm = {in_data[W-2:0], in_data[W-1]};
      default: perm = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= perm;
    end
  end

endmodule

// File: rtl/swap_arbiter.sv
// Round-robin arbiter feeding one shared permute stage, with a single-entry
// valid/ready output register tagged by requester id and a handshake counter.
module swap_arbiter
  import swap_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*W-1:0]             req_data,
  input  logic [NREQ*2-1:0]             req_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  out_data,
  output logic [id_width(NREQ)-1:0]     out_id,
  output logic [CNTW-1:0]               out_cnt
);

  localparam int unsigned IDW = id_width(NREQ);

  state_e         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win_idx;
  logic           any_valid;
  logic           free;
  logic           accept;
  logic [W-1:0]   win_data;
  logic [1:0]     win_mode;

  // Scan from the RR pointer; the first valid requester wins.
  always_comb begin : arbitrate
    int unsigned idx;
    any_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign free      = !out_valid || out_ready;
  assign accept    = any_valid && free && !rst;
  assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
  assign win_data  = req_data[win_idx*W +: W];
  assign win_mode  = req_mode[win_idx*2 +: 2];

  bit_permute_stage #(
    .W (W)
  ) u_permute (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .mode    (win_mode),
    .in_data (win_data),
    .q       (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      ptr       <= '0;
      out_cnt   <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_cnt <= out_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          // Drain and refill in the same cycle keeps the slot full.
          if (out_ready && !accept) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
      if (accept) begin
        out_id <= win_idx;
        ptr    <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_swap_arbiter.sv
// Scoreboard bench for swap_arbiter (NREQ=3, W=4, CNTW=4).
module tb_swap_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned W    = 4;
  localparam int unsigned CNTW = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*2-1:0] req_mode;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [IDW-1:0]    out_id;
  logic [CNTW-1:0]   out_cnt;

  swap_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;

  exp_t            sb[$];
  logic            mv;
  int              ptr_m;
  logic [CNTW-1:0] cnt_m;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] perm_ref(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) begin
      case (m)
        2'd0: r[j] = d[j];
        2'd1: r[j] = d[j ^ 1];
        2'd2: r[j] = d[W-1-j];
        default: r[j] = d[(j + W - 1) % W];
      endcase
    end
    return r;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic [1:0] m);
    req_valid[i]       = v;
    req_data[i*W +: W] = d;
    req_mode[i*2 +: 2] = m;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_data  = '0;
    req_mode  = '0;
  endtask

  // One clock: check pre-edge outputs against the model, then advance it.
  task automatic step();
    int              win;
    int              idx;
    logic            free;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    if (rst) begin
      check_val("ready_in_rst", 32'(req_ready), 0);
      sb.delete();
      mv    = 1'b0;
      ptr_m = 0;
      cnt_m = '0;
    end else begin
      check_val("out_valid", 32'(out_valid), 32'(mv));
      check_val("out_cnt", 32'(out_cnt), 32'(cnt_m));
      if (mv) begin
        if (sb.size() == 0) begin
          check_val("sb_depth", 32'(sb.size()), 1);
        end else begin
          check_val("out_data", 32'(out_data), 32'(sb[0].data));
          check_val("out_id", 32'(out_id), 32'(sb[0].id));
        end
      end
      free = !mv || out_ready;
      win  = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      exp_rdy = (win >= 0 && free) ? NREQ'(1 << win) : '0;
      check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_val("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      if (mv && out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        cnt_m = cnt_m + 1'b1;
        mv    = 1'b0;
      end
      if (win >= 0 && free) begin
        sb.push_back('{IDW'(win), perm_ref(req_data[win*W +: W], req_mode[win*2 +: 2])});
        ptr_m = (win + 1) % NREQ;
        mv    = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [1:0]   mode;
    logic [W-1:0] dout;
  } mode_vec_t;

  mode_vec_t mode_tbl[7] = '{
    '{4'b0011, 2'd0, 4'b0011}, '{4'b0011, 2'd1, 4'b0011},
    '{4'b0011, 2'd2, 4'b1100}, '{4'b0011, 2'd3, 4'b0110},
    '{4'b0001, 2'd1, 4'b0010}, '{4'b0001, 2'd2, 4'b1000},
    '{4'b0001, 2'd3, 4'b0010}
  };

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    clear_reqs();
    mv    = 1'b0;
    ptr_m = 0;
    cnt_m = '0;
    step();
    step();
    rst = 1'b0;
    step();
    check_val("rst_out_data", 32'(out_data), 0);
    check_val("rst_out_id", 32'(out_id), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);

    // single request, swap-pairs mode
    set_req(0, 1'b1, 4'b0101, 2'd1);
    step();
    clear_reqs();
    check_val("single_data", 32'(out_data), 32'(4'b1010));
    check_val("single_id", 32'(out_id), 0);
    step();
    check_val("single_cnt", 32'(out_cnt), 1);

    // two simultaneous requesters alternate after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 4'b0101, 2'd1);
    set_req(1, 1'b1, 4'b1111, 2'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("alt_id", 32'(out_id), 32'(k % 2));
      check_val("alt_data", 32'(out_data), (k % 2 == 0) ? 32'(4'b1010) : 32'(4'b1111));
    end

    // backpressure then drain-and-refill
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b1;
    step();
    check_val("refill_valid", 32'(out_valid), 1);
    clear_reqs();

    // permutation modes through requester 2
    foreach (mode_tbl[i]) begin
      set_req(2, 1'b1, mode_tbl[i].din, mode_tbl[i].mode);
      step();
      clear_reqs();
      check_val("mode_data", 32'(out_data), 32'(mode_tbl[i].dout));
      check_val("mode_id", 32'(out_id), 2);
    end
    step();

    // reset while a result is held under backpressure
    set_req(1, 1'b1, 4'b1001, 2'd3);
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_reqs();
    check_val("midrst_valid", 32'(out_valid), 0);
    check_val("midrst_cnt", 32'(out_cnt), 0);
    check_val("midrst_data", 32'(out_data), 0);
    out_ready = 1'b1;
    set_req(0, 1'b1, 4'b0110, 2'd2);
    set_req(1, 1'b1, 4'b0111, 2'd0);
    set_req(2, 1'b1, 4'b1000, 2'd1);
    step();
    check_val("post_rst_grant", 32'(out_id), 0);

    // 17 handshakes on a 4-bit counter
    clear_reqs();
    for (int k = 0; k < 16; k++) begin
      set_req(0, 1'b1, W'(k), 2'(k));
      step();
    end
    clear_reqs();
    step();
    check_val("cnt_wrap", 32'(out_cnt), 1);
    check_val("drained_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/swap_arbiter.md
Name: swap_arbiter

Overview:
Round-robin arbiter and sequencer sharing one registered bit-permutation stage among NREQ requesters. Each requester presents a W-bit vector and a permutation mode. The granted request passes through the permute stage in one clock. The result is held in a single-entry output register under valid/ready backpressure, tagged with the requester index.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 2, data width in bits (even, >= 2)
CNTW, 16, width of the completion counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit set per cycle
req_data  input  NREQ*W  packed request vectors; requester i at [i*W +: W]
req_mode  input  NREQ*2  packed permutation modes; requester i at [i*2 +: 2]
out_valid  output  1  result valid
out_ready  input  1  downstream accept
out_data  output  W  permuted result
out_id  output  max(1,$clog2(NREQ))  index of the requester that produced out_data
out_cnt  output  CNTW  count of completed output handshakes

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_id=0, out_cnt=0, RR pointer=0, FSM=IDLE. req_ready is all-zero while rst=1.
- Slot free condition: free = !out_valid || out_ready.
- Arbitration is combinational. Starting at the RR pointer, the first i with req_valid[i]=1 wins. req_ready[i] = win[i] && free && !rst.
- Accept: a request is accepted when req_valid[i] && req_ready[i].
  - Next cycle: out_valid=1, out_data=perm(req_data[i], req_mode[i]), out_id=i.
  - The RR pointer moves to (i+1) mod NREQ.
  - Latency is exactly 1 cycle. Throughput is 1 per cycle while out_ready=1.
- Modes (perm):
  - 0 = pass-through.
  - 1 = swap adjacent pairs: out[2k]=in[2k+1], out[2k+1]=in[2k].
  - 2 = full bit reverse: out[j]=in[W-1-j].
  - 3 = rotate left by 1: out[j]=in[(j-1) mod W].
- FSM states:
  - IDLE: out_valid=0.
  - FULL: out_valid=1.
- FSM transitions:
  - IDLE -> FULL on accept.
  - FULL with out_ready=1: FULL -> FULL if a new request is accepted the same cycle (drain and refill simultaneously), otherwise FULL -> IDLE.
  - FULL with out_ready=0: hold. out_data and out_id stay stable, req_ready=0, RR pointer unchanged.
- out_cnt increments by 1 on each out_valid && out_ready. It wraps from 2^CNTW-1 to 0.
- No request valid: no state change except drain.
- out_ready while out_valid=0 is ignored.
- Requesters may drop or change req_valid while not accepted. The arbiter re-evaluates every cycle with no lock.
- Reset mid-operation discards any held result without a handshake. out_cnt is cleared.
- NREQ=1: the RR pointer is constant 0 and out_id is 1 bit, fixed at 0.

Decomposition:
- Package swap_arbiter_pkg holds:
  - enum perm_mode_e {PM_PASS=0, PM_SWAP=1, PM_REV=2, PM_ROTL=3};
  - FSM enum {ST_IDLE, ST_FULL};
  - function for the id width.
- Sub-module bit_permute_stage (parameter W):
  - inputs clk, rst, load, mode, in_data; outputs q.
  - Registered permutation.
  - Reset to 0; loads only when load=1.
- The arbiter, FSM, RR pointer and counter live in swap_arbiter.

Test Plan:
- Single request, mode 1: NREQ=2, W=2, req_valid=2'b01, req_data[1:0]=2'b01. Required: accepted cycle t; at t+1 out_valid=1, out_data=2'b10, out_id=0. With out_ready=1, out_cnt=1 after the handshake.
- Simultaneous requests after reset: both valid, data0=2'b01 mode 1, data1=2'b11 mode 0, out_ready=1. Required: out_id sequence 0, 1, 0, 1 on consecutive cycles; data 2'b10, 2'b11 alternating; never two req_ready bits set together.
- Backpressure: out_ready=0 for 3 cycles after the first result. Required: out_valid, out_data and out_id stable; req_ready=0. Then out_ready=1 with a pending request: drain and refill in the same cycle, out_valid stays 1.
- Modes with W=4, in=4'b0011: mode 0 -> 4'b0011, mode 1 -> 4'b0011, mode 2 -> 4'b1100, mode 3 -> 4'b0110. Repeat with in=4'b0001: mode 1 -> 4'b0010, mode 2 -> 4'b1000, mode 3 -> 4'b0010.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0. Required: next cycle out_valid=0, out_cnt=0, out_data=0. The first grant after reset goes to requester 0.
- Counter wrap: CNTW=4, perform 17 handshakes. Required: out_cnt=1 after wrapping through 15 -> 0.
